alu_issue: RTL and testbench

Operand-issue stage that feeds the CPU ALU. It accepts decoded instruction fields over a valid/ready handshake and reads both source operands from a 32x32 register file. It blocks on read-after-write and write-after-write hazards with a pending-write scoreboard. It presents registered operands, immediate, immediate select and opcode to the ALU, and takes completed results back on a writeback port.

---
 rtl/alu_issue.sv | 150 +++++++++++++++
 tb/tb_alu_issue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Operand-issue stage: register file, pending-write scoreboard and a one-entry issue register.
// Define ALU_ISSUE_BYPASS_EN to forward same-cycle writeback into operands and hazard clearing.
module alu_issue #(
  parameter int unsigned NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_wr_en,
  input  logic [2:0]  in_op,
  input  logic        in_immd_sel,
  input  logic [16:0] in_immd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] reg1_data,
  output logic [31:0] reg2_data,
  output logic [16:0] immd,
  output logic        immd_sel,
  output logic [2:0]  op,
  output logic [4:0]  out_rd,
  output logic        out_wr_en,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [31:0]      rf_q [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;

  logic        valid_q, valid_d;
  logic [31:0] r1_q, r1_d, r2_q, r2_d;
  logic [16:0] immd_q, immd_d;
  logic        sel_q, sel_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        wr_q, wr_d;

  logic        fwd1, fwd2, fwdd;
  logic        haz1, haz2, hazd, hazard;
  logic        accept;
  logic [31:0] opnd1, opnd2;

`ifdef ALU_ISSUE_BYPASS_EN
  assign fwd1 = wb_en && (wb_rd == in_rs1);
  assign fwd2 = wb_en && (wb_rd == in_rs2);
  assign fwdd = wb_en && (wb_rd == in_rd);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
  assign fwdd = 1'b0;
`endif

  // Forward terms are tied low without bypass, leaving only registered pending bits.
  always_comb begin
    haz1   = (in_rs1 != '0) && pending_q[in_rs1] && !fwd1;
    haz2   = (in_rs2 != '0) && !in_immd_sel && pending_q[in_rs2] && !fwd2;
    hazd   = (in_rd != '0) && in_wr_en && pending_q[in_rd] && !fwdd;
    hazard = haz1 || haz2 || hazd;
  end

  assign in_ready = (!valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    opnd1 = '0;
    opnd2 = '0;
    if (in_rs1 != '0) opnd1 = fwd1 ? wb_data : rf_q[in_rs1];
    if (in_rs2 != '0) opnd2 = fwd2 ? wb_data : rf_q[in_rs2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Set is applied after clear so a same-cycle issue to the written index stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) pending_d[wb_rd] = 1'b0;
    if (accept && in_wr_en && (in_rd != '0)) pending_d[in_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    immd_d  = immd_q;
    sel_d   = sel_q;
    op_d    = op_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (accept) begin
      valid_d = 1'b1;
      r1_d    = opnd1;
      r2_d    = opnd2;
      immd_d  = in_immd;
      sel_d   = in_immd_sel;
      op_d    = in_op;
      rd_d    = in_rd;
      wr_d    = in_wr_en;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      immd_q  <= '0;
      sel_q   <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      immd_q  <= immd_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign out_valid = valid_q;
  assign reg1_data = r1_q;
  assign reg2_data = r2_q;
  assign immd      = immd_q;
  assign immd_sel  = sel_q;
  assign op        = op_q;
  assign out_rd    = rd_q;
  assign out_wr_en = wr_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus pushes expected issue records, a negedge monitor checks them.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_wr_en = 1'b0;
  logic [2:0]  in_op = '0;
  logic        in_immd_sel = 1'b0;
  logic [16:0] in_immd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] reg1_data, reg2_data;
  logic [16:0] immd;
  logic        immd_sel;
  logic [2:0]  op;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  alu_issue #(.NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_op(in_op), .in_immd_sel(in_immd_sel), .in_immd(in_immd),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .immd(immd), .immd_sel(immd_sel), .op(op),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [16:0] immd;
    logic        sel;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        wr;
  } issue_t;

  issue_t sb[$];
  issue_t got;
  int     total  = 0;
  int     passed = 0;

  function automatic issue_t mk(logic [31:0] r1, logic [31:0] r2, logic [16:0] im,
                                logic sel, logic [2:0] o, logic [4:0] rd, logic wr);
    mk = '{r1: r1, r2: r2, immd: im, sel: sel, op: o, rd: rd, wr: wr};
  endfunction

  // Every valid cycle is compared to the head record, so held outputs are checked each cycle.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      got = {reg1_data, reg2_data, immd, immd_sel, op, out_rd, out_wr_en};
      total++;
      if (sb.size() == 0) begin
        $display("FAIL issue_unexpected: got %h, required no valid output", got);
      end else if (got !== sb[0]) begin
        $display("FAIL issue_record: got %h, required %h", got, sb[0]);
      end else begin
        passed++;
      end
      if (out_ready && sb.size() != 0) void'(sb.pop_front());
    end
  end

  task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) $display("FAIL %s: got %0h, required %0h", name, g, e);
    else         passed++;
  endtask

  task automatic set_in(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic wr,
                        logic [2:0] o, logic sel, logic [16:0] im);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wr_en = wr;
    in_op = o; in_immd_sel = sel; in_immd = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_back(logic [4:0] rd, logic [31:0] d);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  // Offer the current fields and wait (bounded) for acceptance; checks the stall length.
  task automatic send(input string name, input int exp_wait, input issue_t e);
    int w;
    w = 0;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 20) break;
    end
    if (w > 20) begin
      chk({name, "_timeout"}, 64'd1, 64'd0);
      #1;
    end else begin
      chk({name, "_wait"}, 64'(w), 64'(exp_wait));
      @(posedge clk);
      sb.push_back(e);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_stall(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, 64'(in_ready), 64'd0);
      tick();
    end
  endtask

  // Fields are held with in_valid=1; a writeback to rd releases the hazard.
  task automatic release_wb(input string name, input logic [4:0] rd, input logic [31:0] d,
                            input issue_t e);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    @(negedge clk);
`ifdef ALU_ISSUE_BYPASS_EN
    chk({name, "_rdy_wb"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    sb.push_back(e);
    #1;
    wb_en = 1'b0;
`else
    chk({name, "_rdy_wb"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    @(negedge clk);
    chk({name, "_rdy_after"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    sb.push_back(e);
    #1;
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_reg1", 64'(reg1_data), 64'd0);
    chk("rst_reg2", 64'(reg2_data), 64'd0);
    chk("rst_tag", 64'({immd, immd_sel, op, out_rd, out_wr_en}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Basic issue: r5 written, ADD rs1=5 rd=6
    write_back(5'd5, 32'h0000_1234);
    set_in(5'd5, 5'd0, 5'd6, 1'b1, 3'd0, 1'b0, 17'h00012);
    send("add", 0, mk(32'h1234, 32'h0, 17'h00012, 1'b0, 3'd0, 5'd6, 1'b1));

    // RAW + WAW on r6, released by writeback of 0xDEADBEEF
    set_in(5'd6, 5'd0, 5'd6, 1'b1, 3'd1, 1'b0, 17'h0);
    in_valid = 1'b1;
    expect_stall("raw6_stall", 2);
    release_wb("raw6", 5'd6, 32'hDEAD_BEEF, mk(32'hDEAD_BEEF, 32'h0, 17'h0, 1'b0, 3'd1, 5'd6, 1'b1));

    // Immediate select ignores pending rs2=6; operand still read from the file
    set_in(5'd5, 5'd6, 5'd9, 1'b0, 3'd7, 1'b1, 17'h1FFFF);
    send("immd", 0, mk(32'h1234, 32'hDEAD_BEEF, 17'h1FFFF, 1'b1, 3'd7, 5'd9, 1'b0));

    // WAW on r7, then RAW on the re-pended r7
    set_in(5'd0, 5'd0, 5'd7, 1'b1, 3'd0, 1'b0, 17'h0);
    send("wr7", 0, mk(32'h0, 32'h0, 17'h0, 1'b0, 3'd0, 5'd7, 1'b1));
    set_in(5'd0, 5'd0, 5'd7, 1'b1, 3'd5, 1'b0, 17'h3);
    in_valid = 1'b1;
    expect_stall("waw_stall", 2);
    release_wb("waw7", 5'd7, 32'h0000_0077, mk(32'h0, 32'h0, 17'h3, 1'b0, 3'd5, 5'd7, 1'b1));
    set_in(5'd7, 5'd0, 5'd12, 1'b1, 3'd6, 1'b0, 17'h0);
    in_valid = 1'b1;
    expect_stall("waw_repend", 2);
    release_wb("raw7", 5'd7, 32'h0000_0099, mk(32'h99, 32'h0, 17'h0, 1'b0, 3'd6, 5'd12, 1'b1));

    // Backpressure: hold X three cycles, then drain and accept Y together
    set_in(5'd5, 5'd0, 5'd0, 1'b0, 3'd2, 1'b0, 17'h0);
    send("bp_x", 0, mk(32'h1234, 32'h0, 17'h0, 1'b0, 3'd2, 5'd0, 1'b0));
    out_ready = 1'b0;
    set_in(5'd0, 5'd5, 5'd11, 1'b1, 3'd3, 1'b0, 17'h0);
    in_valid = 1'b1;
    expect_stall("bp_stall", 3);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy_drain", 64'(in_ready), 64'd1);
    @(posedge clk);
    sb.push_back(mk(32'h0, 32'h1234, 17'h0, 1'b0, 3'd3, 5'd11, 1'b1));
    #1;
    in_valid = 1'b0;

    // Writes to r0 are discarded
    write_back(5'd0, 32'hFFFF_FFFF);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 3'd1, 1'b0, 17'h0);
    send("r0", 0, mk(32'h0, 32'h0, 17'h0, 1'b0, 3'd1, 5'd0, 1'b0));

    // Asynchronous reset while an instruction is held
    set_in(5'd5, 5'd0, 5'd10, 1'b1, 3'd0, 1'b0, 17'h0);
    send("pre_rst", 0, mk(32'h1234, 32'h0, 17'h0, 1'b0, 3'd0, 5'd10, 1'b1));
    out_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_reg1", 64'(reg1_data), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    set_in(5'd10, 5'd6, 5'd6, 1'b1, 3'd4, 1'b0, 17'h0);
    send("post_rst", 0, mk(32'h0, 32'h0, 17'h0, 1'b0, 3'd4, 5'd6, 1'b1));
    write_back(5'd5, 32'h0000_ABCD);
    set_in(5'd5, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 17'h0);
    send("post_rst_wb", 0, mk(32'hABCD, 32'h0, 17'h0, 1'b0, 3'd0, 5'd0, 1'b0));

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
